// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row sequencing, column synchronizer, debounce, key encode and CPU hand-off.
// Define KEYPAD_FIFO_EN to replace the single holding register with a 4-entry key FIFO.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEB_SAMPLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] COL,
  output logic [3:0] ROW,
  input  logic       INT_ACK,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       INTERRUPT,
  output logic       OVERFLOW
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEB_SAMPLES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEB_SAMPLES);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_RELEASE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       col_s1_q, col_s2_q;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             tick_c, one_hot_c, accept_c;
  logic [3:0]       new_code_c;

  function automatic logic [3:0] key_code_f(input logic [1:0] r, input logic [2:0] c);
    logic [3:0] ci;
    ci = c[0] ? 4'd0 : (c[1] ? 4'd1 : 4'd2);
    if (r == 2'd3) begin
      key_code_f = c[0] ? 4'hA : (c[1] ? 4'h0 : 4'hB);
    end else begin
      key_code_f = 4'({2'b00, r}) * 4'd3 + ci + 4'd1;
    end
  endfunction

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
    end else begin
      col_s1_q <= COL;
      col_s2_q <= col_s1_q;
    end
  end

  assign tick_c     = (div_q == DIV_MAX);
  assign one_hot_c  = (col_s2_q == 3'b001) || (col_s2_q == 3'b010) || (col_s2_q == 3'b100);
  assign new_code_c = key_code_f(row_idx_q, cand_q);

  always_comb begin
    state_d   = state_q;
    div_d     = tick_c ? '0 : div_q + DIV_W'(1);
    row_idx_d = row_idx_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept_c  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (tick_c) begin
          if (one_hot_c) begin
            cand_d  = col_s2_q;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick_c) begin
          if (col_s2_q == cand_q) begin
            if (cnt_q + CNT_W'(1) == DEB_N) begin
              accept_c = 1'b1;
              cnt_d    = '0;
              state_d  = ST_RELEASE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_d     = {row_q[2:0], row_q[3]};
            state_d   = ST_SCAN;
          end
        end
      end
      ST_RELEASE: begin
        if (tick_c) begin
          if (col_s2_q == 3'b000) begin
            if (cnt_q + CNT_W'(1) == DEB_N) begin
              cnt_d     = '0;
              row_idx_d = row_idx_q + 2'd1;
              row_d     = {row_q[2:0], row_q[3]};
              state_d   = ST_SCAN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
    if (state_d != state_q) div_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_SCAN;
      div_q     <= '0;
      row_idx_q <= '0;
      row_q     <= 4'b0001;
      cnt_q     <= '0;
      cand_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0] fifo_q [4];
  logic [3:0] fifo_d [4];
  logic [1:0] head_q, head_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       push_c, pop_c, full_c;
  logic [1:0] tail_c;

  // Key FIFO; the output code register tracks the next head so it stays registered
  always_comb begin
    fifo_d  = fifo_q;
    head_d  = head_q;
    fcnt_d  = fcnt_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    full_c  = (fcnt_q == 3'd4);
    pop_c   = INT_ACK && (fcnt_q != 3'd0);
    push_c  = accept_c && (!full_c || pop_c);
    tail_c  = head_q + fcnt_q[1:0];
    if (push_c) fifo_d[tail_c] = new_code_c;
    head_d  = head_q + {1'b0, pop_c};
    fcnt_d  = fcnt_q + 3'({2'b00, push_c}) - 3'({2'b00, pop_c});
    if (fcnt_d != 3'd0) code_d = fifo_d[head_d];
    valid_d = (fcnt_d != 3'd0);
    if (accept_c && full_c && !pop_c) begin
      ovf_d = 1'b1;
    end else if (INT_ACK && (fcnt_d == 3'd0)) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_q <= '{default: '0};
      head_q <= '0;
      fcnt_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      head_q <= head_d;
      fcnt_q <= fcnt_d;
    end
  end
`else
  // Single holding register; an acknowledge in the accept cycle frees the slot for the new key
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (INT_ACK) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (accept_c) begin
      if (!valid_q || INT_ACK) begin
        code_d  = new_code_c;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ROW       = row_q;
  assign KEY_CODE  = code_q;
  assign KEY_VALID = valid_q;
  assign INTERRUPT = valid_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad model drives COL from ROW; a queue-based monitor checks each key report.
module tb_keypad_scan_ctrl;

  localparam int SD  = 4;
  localparam int DS  = 3;
  localparam int LAT = (SD - 1) + (DS - 1) * SD + 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] COL;
  logic [3:0] ROW;
  logic       INT_ACK = 1'b0;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID, INTERRUPT, OVERFLOW;

  logic       key_down = 1'b0;
  int         key_r = 0;
  int         key_c = 0;
  logic [2:0] col_force = 3'b000;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_SAMPLES(DS)) dut (
    .CLK(CLK), .RST_N(RST_N), .COL(COL), .ROW(ROW), .INT_ACK(INT_ACK),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .INTERRUPT(INTERRUPT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Matrix keypad: the pressed key connects its row drive to its column line
  always_comb COL = col_force | ((key_down && ROW[key_r]) ? 3'(1 << key_c) : 3'b000);

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic prev_v = 1'b0;
    logic ack_prev;
    exp_t e;
    forever begin
      @(posedge CLK);
      ack_prev = INT_ACK;
      @(negedge CLK);
      if (KEY_VALID && (!prev_v || ack_prev)) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_report: code 0x%0h at cycle %0d, none expected", KEY_CODE, cyc);
        end else begin
          e = sb.pop_front();
          check("report_code", int'(KEY_CODE), int'(e.code));
          check("report_irq", int'(INTERRUPT), 1);
          if (e.at >= 0) check("report_cycle", cyc, e.at);
        end
      end
      prev_v = KEY_VALID;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Returns at the first negedge on which row r becomes driven
  task automatic wait_row(input int r);
    logic [3:0] tgt;
    int t;
    tgt = 4'(1 << r);
    t = 0;
    while (ROW == tgt && t < 64) begin @(negedge CLK); t++; end
    while (ROW != tgt && t < 64) begin @(negedge CLK); t++; end
    if (t >= 64) begin
      vecs++;
      errs++;
      $display("FAIL wait_row%0d: timeout, got ROW=%b", r, ROW);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge CLK); t++; end
    if (sb.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain: %0d reports still pending, expected 0", sb.size());
    end
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code,
                       input bit expect_rep, input bit timed, output int n0);
    wait_row(r);
    n0 = cyc;
    key_r = r;
    key_c = c;
    key_down = 1'b1;
    if (expect_rep) sb.push_back('{code: code, at: (timed ? cyc + LAT : -1)});
  endtask

  task automatic release_key();
    key_down = 1'b0;
    cycles(24);
  endtask

  task automatic ack(input logic exp_v, input logic [3:0] exp_code, input logic exp_ovf);
    INT_ACK = 1'b1;
    @(negedge CLK);
    INT_ACK = 1'b0;
    check("ack_valid", int'(KEY_VALID), int'(exp_v));
    check("ack_irq", int'(INTERRUPT), int'(exp_v));
    check("ack_code", int'(KEY_CODE), int'(exp_code));
    check("ack_ovf", int'(OVERFLOW), int'(exp_ovf));
  endtask

  task automatic check_reset_outputs();
    check("rst_row", int'(ROW), 1);
    check("rst_code", int'(KEY_CODE), 0);
    check("rst_valid", int'(KEY_VALID), 0);
    check("rst_irq", int'(INTERRUPT), 0);
    check("rst_ovf", int'(OVERFLOW), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    fork
      monitor();
    join_none

    // Reset values and idle row rotation
    cycles(3);
    check_reset_outputs();
    RST_N = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("row_rotate", int'(ROW), 1 << ((k / 4) % 4));
      cycles(1);
    end
    check("idle_valid", int'(KEY_VALID), 0);

    // Key 8, held across the acknowledge: single report
    press(2, 1, 4'h8, 1'b1, 1'b1, n0);
    wait_drain();
    cycles(8);
    ack(1'b0, 4'h8, 1'b0);
    cycles(8);
    release_key();

    // One-sample glitch on row 3: enters debounce, then resumes at row 0
    wait_row(3);
    cycles(1);
    col_force = 3'b001;
    cycles(3);
    check("glitch_row_held", int'(ROW), 4'b1000);
    cycles(1);
    col_force = 3'b000;
    cycles(3);
    check("glitch_row_next", int'(ROW), 4'b0001);
    cycles(16);

    // Key 5 then # without acknowledge
    press(1, 1, 4'h5, 1'b1, 1'b1, n0);
    wait_drain();
    cycles(4);
    release_key();
`ifdef KEYPAD_FIFO_EN
    press(3, 2, 4'hB, 1'b1, 1'b0, n0);
`else
    press(3, 2, 4'hB, 1'b0, 1'b0, n0);
`endif
    cycles(LAT - 1);
    check("ovf_before_accept", int'(OVERFLOW), 0);
    cycles(1);
`ifdef KEYPAD_FIFO_EN
    check("ovf_after_accept", int'(OVERFLOW), 0);
`else
    check("ovf_after_accept", int'(OVERFLOW), 1);
`endif
    check("ovf_code_kept", int'(KEY_CODE), 4'h5);
    check("ovf_valid_kept", int'(KEY_VALID), 1);
    release_key();
`ifdef KEYPAD_FIFO_EN
    ack(1'b1, 4'hB, 1'b0);
    wait_drain();
    ack(1'b0, 4'hB, 1'b0);
`else
    ack(1'b0, 4'h5, 1'b0);
`endif

    // Two columns at once is never a key
    col_force = 3'b011;
    wait_row(0);
    cycles(4);
    check("multi_row1", int'(ROW), 4'b0010);
    cycles(4);
    check("multi_row2", int'(ROW), 4'b0100);
    cycles(4);
    check("multi_row3", int'(ROW), 4'b1000);
    cycles(4);
    check("multi_row0", int'(ROW), 4'b0001);
    col_force = 3'b000;
    check("multi_valid", int'(KEY_VALID), 0);
    cycles(8);

    // Reset while debouncing key 1
    press(0, 0, 4'h1, 1'b0, 1'b0, n0);
    cycles(6);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs();
    key_down = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    cycles(4);
    check("rst_deb_restart", int'(ROW), 4'b0010);
    cycles(30);

    // Reset while waiting for release of key 9
    press(2, 2, 4'h9, 1'b1, 1'b1, n0);
    wait_drain();
    cycles(4);
    check("rel_valid_before_rst", int'(KEY_VALID), 1);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs();
    key_down = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    cycles(4);
    check("rst_rel_restart", int'(ROW), 4'b0010);
    cycles(30);

    // Acknowledge with nothing pending changes nothing
    ack(1'b0, 4'h0, 1'b0);
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
